// File: rtl/i2c_mem_responder.sv
// Multi-bus I2C memory target: one target engine and byte memory per bus, answering BASE_ADDR+n.
// Optional general-call support is enabled by defining I2C_MEM_RESPONDER_GCALL_EN.
module i2c_mem_responder #(
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter int NUM_I2C_BUSSES = 1,
  parameter int MEM_DEPTH      = 16,
  parameter logic [I2C_ADDR_WIDTH-1:0] BASE_ADDR = 7'h22
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_I2C_BUSSES-1:0]     scl_i,
  input  logic [NUM_I2C_BUSSES-1:0]     sda_i,
  output logic [NUM_I2C_BUSSES-1:0]     sda_o,
  output logic [NUM_I2C_BUSSES-1:0]     busy_o,
  output logic [NUM_I2C_BUSSES-1:0]     done_o,
  output logic [NUM_I2C_BUSSES*8-1:0]   wr_cnt_o
);

  localparam int PW  = $clog2(MEM_DEPTH);
  localparam int AW1 = I2C_ADDR_WIDTH + 1;
  localparam int RXW = (AW1 > I2C_DATA_WIDTH) ? AW1 : I2C_DATA_WIDTH;
  localparam int CW  = $clog2(RXW + 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_PTR       = 4'd3;
  localparam logic [3:0] S_PTR_ACK   = 4'd4;
  localparam logic [3:0] S_WR_DATA   = 4'd5;
  localparam logic [3:0] S_WR_ACK    = 4'd6;
  localparam logic [3:0] S_RD_DATA   = 4'd7;
  localparam logic [3:0] S_RD_ACK    = 4'd8;
  localparam logic [3:0] S_WAIT_STOP = 4'd9;

  for (genvar n = 0; n < NUM_I2C_BUSSES; n++) begin : g_bus
    localparam logic [I2C_ADDR_WIDTH-1:0] OWN_ADDR = I2C_ADDR_WIDTH'(BASE_ADDR + n);

    logic r_scl_s1, r_scl_s2, r_scl_s3;
    logic r_sda_s1, r_sda_s2, r_sda_s3;
    logic r_ev_start, r_ev_stop, r_ev_rise, r_ev_fall, r_sda_bit;
    logic w_scl_steady_hi, w_start, w_stop, w_rise, w_fall;

    logic [3:0]                r_state;
    logic [CW-1:0]             r_cnt;
    logic [RXW-1:0]            r_rx;
    logic [I2C_DATA_WIDTH-1:0] r_tx;
    logic [PW-1:0]             r_ptr;
    logic [7:0]                r_wr_cnt;
    logic                      r_sda, r_busy, r_done, r_rw, r_gcall, r_mack;
    logic [I2C_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic [CW-1:0]             w_tgt;
    logic                      w_addr_match, w_gcall_hit;
    logic [I2C_DATA_WIDTH-1:0] w_rd_byte;
    logic [PW-1:0]             w_wr_idx;

    // START/STOP only qualify while SCL sits high in both compared samples
    assign w_scl_steady_hi = r_scl_s2 & r_scl_s3;
    assign w_start = w_scl_steady_hi & r_sda_s3 & ~r_sda_s2;
    assign w_stop  = w_scl_steady_hi & ~r_sda_s3 & r_sda_s2;
    assign w_rise  = r_scl_s2 & ~r_scl_s3;
    assign w_fall  = ~r_scl_s2 & r_scl_s3;

    assign w_rd_byte = r_mem[r_ptr];
    assign w_wr_idx  = r_gcall ? {PW{1'b0}} : r_ptr;

    // Bit count that closes the current byte phase (address byte carries the R/W bit)
    always_comb begin
      if (r_state == S_ADDR) begin
        w_tgt = CW'(AW1);
      end else begin
        w_tgt = CW'(I2C_DATA_WIDTH);
      end
    end

    // Address decode of the received address byte
    always_comb begin
      w_addr_match = 1'b0;
      w_gcall_hit  = 1'b0;
      if (r_rx[AW1-1:1] == OWN_ADDR) begin
        w_addr_match = 1'b1;
      end else begin
`ifdef I2C_MEM_RESPONDER_GCALL_EN
        if (r_rx[AW1-1:0] == {AW1{1'b0}}) begin
          w_addr_match = 1'b1;
          w_gcall_hit  = 1'b1;
        end else begin
          w_addr_match = 1'b0;
        end
`else
        w_addr_match = 1'b0;
`endif
      end
    end

    // Pin synchronizers and registered bus events
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_s3 <= 1'b1;
        r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_s3 <= 1'b1;
        r_ev_start <= 1'b0; r_ev_stop <= 1'b0;
        r_ev_rise  <= 1'b0; r_ev_fall <= 1'b0;
        r_sda_bit  <= 1'b1;
      end else begin
        r_scl_s1 <= scl_i[n]; r_scl_s2 <= r_scl_s1; r_scl_s3 <= r_scl_s2;
        r_sda_s1 <= sda_i[n]; r_sda_s2 <= r_sda_s1; r_sda_s3 <= r_sda_s2;
        r_ev_start <= w_start;
        r_ev_stop  <= w_stop;
        r_ev_rise  <= w_rise;
        r_ev_fall  <= w_fall;
        r_sda_bit  <= r_sda_s2;
      end
    end

    // Target FSM: sample on SCL rise, drive SDA on SCL fall, START/STOP override everything
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        r_state  <= S_IDLE;
        r_cnt    <= {CW{1'b0}};
        r_rx     <= {RXW{1'b0}};
        r_tx     <= {I2C_DATA_WIDTH{1'b0}};
        r_ptr    <= {PW{1'b0}};
        r_wr_cnt <= 8'd0;
        r_sda    <= 1'b1;
        r_busy   <= 1'b0;
        r_done   <= 1'b0;
        r_rw     <= 1'b0;
        r_gcall  <= 1'b0;
        r_mack   <= 1'b0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
          r_mem[i] <= {I2C_DATA_WIDTH{1'b0}};
        end
      end else begin
        r_done <= 1'b0;
        if (r_ev_start) begin
          r_state <= S_ADDR;
          r_cnt   <= {CW{1'b0}};
          r_sda   <= 1'b1;
          r_gcall <= 1'b0;
        end else if (r_ev_stop) begin
          r_state <= S_IDLE;
          r_sda   <= 1'b1;
          if (r_busy) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end else if (r_ev_rise) begin
          case (r_state)
            S_ADDR, S_PTR, S_WR_DATA: begin
              if (r_cnt != w_tgt) begin
                r_rx  <= {r_rx[RXW-2:0], r_sda_bit};
                r_cnt <= r_cnt + CW'(1'b1);
              end
            end
            S_RD_DATA: begin
              if (r_cnt != CW'(I2C_DATA_WIDTH)) begin
                r_cnt <= r_cnt + CW'(1'b1);
              end
            end
            S_RD_ACK: r_mack <= ~r_sda_bit;
            default: ;
          endcase
        end else if (r_ev_fall) begin
          case (r_state)
            S_ADDR: begin
              if (r_cnt == w_tgt) begin
                if (w_addr_match) begin
                  r_sda   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_rw    <= r_rx[0];
                  r_gcall <= w_gcall_hit;
                  r_state <= S_ADDR_ACK;
                end else begin
                  r_sda   <= 1'b1;
                  r_state <= S_WAIT_STOP;
                end
              end
            end
            S_ADDR_ACK: begin
              r_cnt <= {CW{1'b0}};
              if (r_rw) begin
                r_tx    <= w_rd_byte;
                r_sda   <= w_rd_byte[I2C_DATA_WIDTH-1];
                r_ptr   <= r_ptr + PW'(1'b1);
                r_state <= S_RD_DATA;
              end else begin
                r_sda   <= 1'b1;
                r_state <= r_gcall ? S_WR_DATA : S_PTR;
              end
            end
            S_PTR: begin
              if (r_cnt == w_tgt) begin
                r_ptr   <= r_rx[PW-1:0];
                r_sda   <= 1'b0;
                r_state <= S_PTR_ACK;
              end
            end
            S_PTR_ACK: begin
              r_sda   <= 1'b1;
              r_cnt   <= {CW{1'b0}};
              r_state <= S_WR_DATA;
            end
            S_WR_DATA: begin
              if (r_cnt == w_tgt) begin
                r_mem[w_wr_idx] <= r_rx[I2C_DATA_WIDTH-1:0];
                if (!r_gcall) begin
                  r_ptr <= r_ptr + PW'(1'b1);
                end
                if (r_wr_cnt != 8'hFF) begin
                  r_wr_cnt <= r_wr_cnt + 8'd1;
                end
                r_sda   <= 1'b0;
                r_state <= S_WR_ACK;
              end
            end
            S_WR_ACK: begin
              r_sda   <= 1'b1;
              r_cnt   <= {CW{1'b0}};
              r_state <= r_gcall ? S_WAIT_STOP : S_WR_DATA;
            end
            S_RD_DATA: begin
              if (r_cnt == CW'(I2C_DATA_WIDTH)) begin
                r_sda   <= 1'b1;
                r_state <= S_RD_ACK;
              end else begin
                r_sda <= r_tx[I2C_DATA_WIDTH-2];
                r_tx  <= {r_tx[I2C_DATA_WIDTH-2:0], 1'b0};
              end
            end
            S_RD_ACK: begin
              if (r_mack) begin
                r_tx    <= w_rd_byte;
                r_sda   <= w_rd_byte[I2C_DATA_WIDTH-1];
                r_ptr   <= r_ptr + PW'(1'b1);
                r_cnt   <= {CW{1'b0}};
                r_state <= S_RD_DATA;
              end else begin
                r_sda   <= 1'b1;
                r_state <= S_WAIT_STOP;
              end
            end
            default: ;
          endcase
        end
      end
    end

    assign sda_o[n]          = r_sda;
    assign busy_o[n]         = r_busy;
    assign done_o[n]         = r_done;
    assign wr_cnt_o[n*8 +: 8] = r_wr_cnt;
  end

endmodule

// File: tb/tb_i2c_mem_responder.sv
// Scoreboard bench for i2c_mem_responder on two busses: an I2C master model drives directed
// transfers, expectations are queued up front and a negedge monitor pairs them with observations.
module tb_i2c_mem_responder;

  localparam int Q = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_scl, m_sda;
  logic [1:0]  w_sda, dut_sda, busy, done;
  logic [15:0] wr_cnt;

  logic [31:0] exp_q[$];
  string       exp_name_q[$];
  logic [31:0] obs_q[$];
  int          checks = 0;
  int          errors = 0;

  assign w_sda = m_sda & dut_sda;

  always #5 clk = ~clk;

  i2c_mem_responder #(
    .I2C_ADDR_WIDTH(7),
    .I2C_DATA_WIDTH(8),
    .NUM_I2C_BUSSES(2),
    .MEM_DEPTH(16),
    .BASE_ADDR(7'h22)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .scl_i   (m_scl),
    .sda_i   (w_sda),
    .sda_o   (dut_sda),
    .busy_o  (busy),
    .done_o  (done),
    .wr_cnt_o(wr_cnt)
  );

  // Monitor: done pulses become observations; every observation is paired with the oldest expectation
  always @(negedge clk) begin
    logic [31:0] a, e;
    string nm;
    for (int b = 0; b < 2; b++) begin
      if (done[b] === 1'b1) obs_q.push_back(32'(wr_cnt[b*8 +: 8]));
    end
    while (obs_q.size() > 0) begin
      a = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual=%0h required=none", a);
      end else begin
        nm = exp_name_q.pop_front();
        e  = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL %s actual=%0h required=%0h", nm, a, e);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic expect_val(input string nm, input logic [31:0] v);
    exp_name_q.push_back(nm);
    exp_q.push_back(v);
  endtask

  task automatic check_now(input string nm, input logic [31:0] act, input logic [31:0] req);
    expect_val(nm, req);
    obs_q.push_back(act);
  endtask

  task automatic bit_cycle(input logic [1:0] mask, input logic [1:0] d, output logic [1:0] o);
    m_sda = (m_sda & ~mask) | (d & mask);
    repeat (Q) @(negedge clk);
    m_scl = m_scl | mask;
    repeat (Q) @(negedge clk);
    o = w_sda;
    repeat (Q) @(negedge clk);
    m_scl = m_scl & ~mask;
    repeat (Q) @(negedge clk);
  endtask

  task automatic frame(input logic [1:0] mask, input logic [8:0] d0, input logic [8:0] d1,
                       output logic [8:0] o0, output logic [8:0] o1);
    logic [1:0] o;
    for (int i = 8; i >= 0; i--) begin
      bit_cycle(mask, {d1[i], d0[i]}, o);
      o0[i] = o[0];
      o1[i] = o[1];
    end
  endtask

  task automatic i2c_start(input logic [1:0] mask);
    m_sda = m_sda | mask;  repeat (Q) @(negedge clk);
    m_scl = m_scl | mask;  repeat (Q) @(negedge clk);
    m_sda = m_sda & ~mask; repeat (Q) @(negedge clk);
    m_scl = m_scl & ~mask; repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_stop(input logic [1:0] mask);
    m_sda = m_sda & ~mask; repeat (Q) @(negedge clk);
    m_scl = m_scl | mask;  repeat (Q) @(negedge clk);
    m_sda = m_sda | mask;  repeat (Q) @(negedge clk);
  endtask

  task automatic wr_byte(input logic [1:0] mask, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [1:0] ack_req);
    logic [8:0] o0, o1;
    if (mask[0]) expect_val($sformatf("ack_bus0_%02h", b0), 32'(ack_req[0]));
    if (mask[1]) expect_val($sformatf("ack_bus1_%02h", b1), 32'(ack_req[1]));
    frame(mask, {b0, 1'b1}, {b1, 1'b1}, o0, o1);
    if (mask[0]) obs_q.push_back(32'(o0[0]));
    if (mask[1]) obs_q.push_back(32'(o1[0]));
  endtask

  task automatic rd_byte(input logic [1:0] mask, input logic [1:0] m_ack,
                         input logic [7:0] e0, input logic [7:0] e1);
    logic [8:0] o0, o1;
    if (mask[0]) expect_val("rd_data_bus0", 32'(e0));
    if (mask[1]) expect_val("rd_data_bus1", 32'(e1));
    frame(mask, {8'hFF, m_ack[0]}, {8'hFF, m_ack[1]}, o0, o1);
    if (mask[0]) obs_q.push_back(32'(o0[8:1]));
    if (mask[1]) obs_q.push_back(32'(o1[8:1]));
  endtask

  task automatic expect_done(input logic [1:0] mask, input logic [7:0] c0, input logic [7:0] c1);
    if (mask[0]) expect_val("done_wr_cnt_bus0", 32'(c0));
    if (mask[1]) expect_val("done_wr_cnt_bus1", 32'(c1));
  endtask

  initial begin
    logic [1:0] o;
    rst_n = 1'b0;
    m_scl = 2'b11;
    m_sda = 2'b11;
    repeat (4) @(negedge clk);
    check_now("rst_sda_o",  32'(dut_sda), 32'h3);
    check_now("rst_busy",   32'(busy),    32'h0);
    check_now("rst_done",   32'(done),    32'h0);
    check_now("rst_wr_cnt", 32'(wr_cnt),  32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Pointer-addressed write on bus 0
    i2c_start(2'b01);
    wr_byte(2'b01, 8'h44, 8'hFF, 2'b00);
    check_now("busy_after_addr", 32'(busy), 32'h1);
    wr_byte(2'b01, 8'h03, 8'hFF, 2'b00);
    wr_byte(2'b01, 8'hA5, 8'hFF, 2'b00);
    wr_byte(2'b01, 8'h5A, 8'hFF, 2'b00);
    expect_done(2'b01, 8'd2, 8'd0);
    i2c_stop(2'b01);
    check_now("busy_after_stop", 32'(busy), 32'h0);

    // Pointer wrap 15 -> 0
    i2c_start(2'b01);
    wr_byte(2'b01, 8'h44, 8'hFF, 2'b00);
    wr_byte(2'b01, 8'h0F, 8'hFF, 2'b00);
    wr_byte(2'b01, 8'h11, 8'hFF, 2'b00);
    wr_byte(2'b01, 8'h22, 8'hFF, 2'b00);
    expect_done(2'b01, 8'd4, 8'd0);
    i2c_stop(2'b01);

    // Repeated-START read from pointer 3
    i2c_start(2'b01);
    wr_byte(2'b01, 8'h44, 8'hFF, 2'b00);
    wr_byte(2'b01, 8'h03, 8'hFF, 2'b00);
    i2c_start(2'b01);
    wr_byte(2'b01, 8'h45, 8'hFF, 2'b00);
    rd_byte(2'b01, 2'b00, 8'hA5, 8'h00);
    rd_byte(2'b01, 2'b01, 8'h5A, 8'h00);
    check_now("busy_before_stop", 32'(busy), 32'h1);
    expect_done(2'b01, 8'd4, 8'd0);
    i2c_stop(2'b01);
    check_now("busy_after_read_stop", 32'(busy), 32'h0);

    // Read across the wrap point
    i2c_start(2'b01);
    wr_byte(2'b01, 8'h44, 8'hFF, 2'b00);
    wr_byte(2'b01, 8'h0F, 8'hFF, 2'b00);
    i2c_start(2'b01);
    wr_byte(2'b01, 8'h45, 8'hFF, 2'b00);
    rd_byte(2'b01, 2'b00, 8'h11, 8'h00);
    rd_byte(2'b01, 2'b01, 8'h22, 8'h00);
    expect_done(2'b01, 8'd4, 8'd0);
    i2c_stop(2'b01);

    // Address mismatch: NACK, no busy, no done
    i2c_start(2'b01);
    wr_byte(2'b01, 8'h50, 8'hFF, 2'b01);
    check_now("busy_on_mismatch", 32'(busy), 32'h0);
    i2c_stop(2'b01);
    check_now("wr_cnt_after_mismatch", 32'(wr_cnt[7:0]), 32'd4);

    // Concurrent writes on both busses, then concurrent readback
    i2c_start(2'b11);
    wr_byte(2'b11, 8'h44, 8'h46, 2'b00);
    wr_byte(2'b11, 8'h00, 8'h00, 2'b00);
    wr_byte(2'b11, 8'h77, 8'h88, 2'b00);
    expect_done(2'b11, 8'd5, 8'd1);
    i2c_stop(2'b11);
    i2c_start(2'b11);
    wr_byte(2'b11, 8'h44, 8'h46, 2'b00);
    wr_byte(2'b11, 8'h00, 8'h00, 2'b00);
    i2c_start(2'b11);
    wr_byte(2'b11, 8'h45, 8'h47, 2'b00);
    rd_byte(2'b11, 2'b11, 8'h77, 8'h88);
    expect_done(2'b11, 8'd5, 8'd1);
    i2c_stop(2'b11);

    // Reset mid-byte while the target holds SDA low
    i2c_start(2'b01);
    wr_byte(2'b01, 8'h44, 8'hFF, 2'b00);
    wr_byte(2'b01, 8'h03, 8'hFF, 2'b00);
    i2c_start(2'b01);
    wr_byte(2'b01, 8'h45, 8'hFF, 2'b00);
    bit_cycle(2'b01, 2'b11, o);
    check_now("sda_low_before_reset", 32'(dut_sda[0]), 32'h0);
    rst_n = 1'b0;
    #1;
    check_now("sda_released_in_reset", 32'(dut_sda), 32'h3);
    check_now("busy_in_reset", 32'(busy), 32'h0);
    check_now("wr_cnt_in_reset", 32'(wr_cnt), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    i2c_start(2'b01);
    wr_byte(2'b01, 8'h44, 8'hFF, 2'b00);
    wr_byte(2'b01, 8'h03, 8'hFF, 2'b00);
    i2c_start(2'b01);
    wr_byte(2'b01, 8'h45, 8'hFF, 2'b00);
    rd_byte(2'b01, 2'b01, 8'h00, 8'h00);
    expect_done(2'b01, 8'd0, 8'd0);
    i2c_stop(2'b01);

    repeat (20) @(negedge clk);
    while (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s actual=none required=%0h", exp_name_q.pop_front(), exp_q.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_mem_responder.md
# i2c_mem_responder

Synthesizable multi-bus I2C target that answers the I2CMB master, replacing the behavioural slave BFM in lab benches and FPGA bring-up. One independent target engine and byte memory per bus, `NUM_I2C_BUSSES` of them. Each engine sits directly on the open-drain `scl`/`sda` nets driven by the DUT. The block supports pointer-addressed writes, auto-increment reads and repeated START.

## Interface
- `I2C_ADDR_WIDTH`, default 7: target address width.
- `I2C_DATA_WIDTH`, default 8: byte width; bit count per data phase.
- `NUM_I2C_BUSSES`, default 1: number of independent target engines.
- `MEM_DEPTH`, default 16: bytes per bus; power of two, ≥2.
- `BASE_ADDR`, default 7'h22: bus n responds to `BASE_ADDR+n`, truncated to `I2C_ADDR_WIDTH`.

Ports:
- `clk_i`, in, 1: sampling clock; must be ≥8× SCL frequency.
- `rst_i`, in, 1: reset, asynchronous, active-low.
- `scl_i`, in, `NUM_I2C_BUSSES`: SCL per bus.
- `sda_i`, in, `NUM_I2C_BUSSES`: SDA per bus.
- `sda_o`, out, `NUM_I2C_BUSSES`: open-drain SDA drive; 0 pulls the line low, 1 releases it.
- `busy_o`, out, `NUM_I2C_BUSSES`: high from START to STOP while the engine is addressed.
- `done_o`, out, `NUM_I2C_BUSSES`: one-cycle pulse on STOP after an addressed transfer.
- `wr_cnt_o`, out, `NUM_I2C_BUSSES*8`: per-bus count of bytes written to memory since reset; saturates at 255.

## Operation
- Each bus has a 2-flop synchronizer on SCL and SDA, then edge detect. All decisions use the synchronized values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognised in every state, including mid-byte; that covers repeated START. START goes to ADDR. STOP goes to IDLE and releases SDA.
- Bits are sampled on the SCL rising edge, MSB first. `sda_o` is updated on the SCL falling edge.
- States:
  - IDLE
  - ADDR: shift 8 bits.
  - ADDR_ACK: drive 0 if the address matches, otherwise go to WAIT_STOP and release SDA.
  - R/W bit 0 → PTR, then PTR_ACK.
  - R/W bit 1 → RD_DATA, then RD_ACK.
  - PTR loads the pointer with `byte mod MEM_DEPTH`.
  - WR_DATA, then WR_ACK: write `mem[ptr]`, increment `ptr`, increment `wr_cnt`.
  - RD_ACK: master ACK (SDA 0) → next RD_DATA. Master NACK → WAIT_STOP.
  - WAIT_STOP.
- The pointer wraps from `MEM_DEPTH-1` to 0. It persists across transfers, so write-pointer, repeated START, read returns from the set pointer.
- Read: `mem[ptr]` is latched at the RD_DATA entry and `ptr` increments after each byte.
- Engines are fully independent; simultaneous activity on all busses is legal.

## Timing
- Reset values:
  - `sda_o` all 1.
  - `busy_o`, `done_o` all 0.
  - `wr_cnt_o` 0, memory 0, pointers 0.
  - All FSMs in IDLE.
- Latency from a bus edge to the internal event: 3 `clk_i` cycles (2 sync + 1 detect).
- `sda_o` changes 1 cycle after the SCL falling edge is detected, i.e. 4 cycles after the pin edge.
- ACK drive is released on the SCL falling edge that ends the ACK bit.
- `done_o` pulses 4 cycles after the STOP pin edge.
- `busy_o` rises when the address matches at ADDR_ACK. It falls with `done_o`.
- Reset asserted mid-transfer: immediate return to reset values, `sda_o` released asynchronously.
- START and STOP are detected only when SCL is steady high. An SDA edge coincident with an SCL edge in the same sample counts as a data transition, not START/STOP.

## Configuration
- `I2C_MEM_RESPONDER_GCALL_EN`
  - Defined: address 7'h00 with R/W=0 is ACKed by every bus. The following byte is written to `mem[0]` with no pointer phase; further bytes are NACKed, then WAIT_STOP. General-call read is NACKed.
  - Undefined: 7'h00 is treated as a non-matching address.

## Test plan
- Write on bus 0: START, 0x44, pointer 0x03, data 0xA5, 0x5A, STOP → all four bytes ACKed; `mem[3]=0xA5`, `mem[4]=0x5A`; `wr_cnt=2`; one `done_o` pulse.
- Pointer wrap, `MEM_DEPTH=16`: START, 0x44, pointer 0x0F, data 0x11, 0x22, STOP → `mem[15]=0x11`, `mem[0]=0x22`.
- Repeated-START read: START, 0x44, pointer 0x03, then START, 0x45; master ACKs byte 1 and NACKs byte 2; STOP → SDA carries 0xA5 then 0x5A; `busy_o` falls after STOP.
- Address mismatch: START, 0x50 → SDA released during the ACK bit (NACK), no memory change, `done_o` stays 0.
- Bus independence with `NUM_I2C_BUSSES=2`: concurrent writes of 0x77 to bus 0 (0x22) and 0x88 to bus 1 (0x23) at pointer 0 → each memory holds its own byte.
- Reset mid-byte during a read with SDA held low → `sda_o=1` within the same cycle; FSM in IDLE; the next START and address transfer are ACKed normally.
